// File: rtl/axi4_wch_drop_sched.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_wch_drop_sched
//  Description : Orders the AXI4 W channel behind the RAB write-address
//                lookup. Forwarded bursts pass through to the master side;
//                dropped bursts are sunk locally, length-checked and then
//                handed to the B sender as a drop request carrying the ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_wch_drop_sched #(
   parameter int C_AXI_ID_WIDTH = 10,
   parameter int C_QUEUE_DEPTH  = 4
) (
   input  logic                      axi4_aclk,
   input  logic                      axi4_arstn,
   // write decisions from the address lookup
   input  logic                      aw_push_valid,
   output logic                      aw_push_ready,
   input  logic                      aw_push_drop,
   input  logic [C_AXI_ID_WIDTH-1:0] aw_push_id,
   input  logic [7:0]                aw_push_len,
   // slave-side W handshake
   input  logic                      s_axi4_wvalid,
   input  logic                      s_axi4_wlast,
   output logic                      s_axi4_wready,
   // master-side W handshake
   output logic                      m_axi4_wvalid,
   output logic                      m_axi4_wlast,
   input  logic                      m_axi4_wready,
   // drop request towards the B sender
   output logic                      drop_valid,
   output logic [C_AXI_ID_WIDTH-1:0] drop_id,
   input  logic                      drop_ready,
   // burst length error
   output logic                      err_wlast
);

   localparam int PTR_W = (C_QUEUE_DEPTH > 1) ? $clog2(C_QUEUE_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(C_QUEUE_DEPTH);
   localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);
   localparam logic [7:0]       BEAT_MAX   = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_SINK = 2'd2,
      ST_BREQ = 2'd3
   } state_t;

   // queue storage and bookkeeping
   logic                      q_drop [C_QUEUE_DEPTH];
   logic [C_AXI_ID_WIDTH-1:0] q_id   [C_QUEUE_DEPTH];
   logic [7:0]                q_len  [C_QUEUE_DEPTH];
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;
   logic [PTR_W-1:0]          rd_ptr_inc;
   logic [CNT_W-1:0]          count;

   logic                      push;
   logic                      pop;
   logic                      empty;
   logic                      head_drop;
   logic [C_AXI_ID_WIDTH-1:0] head_id;
   logic [7:0]                head_len;
   logic                      next_drop;

   // FSM and beat tracking
   state_t                    state;
   state_t                    state_nxt;
   logic [7:0]                beat_cnt;
   logic                      cnt_clr;
   logic                      cnt_inc;
   logic                      load_drop_id;
   logic                      beat_acc;
   logic                      len_mismatch;

   assign aw_push_ready = (count != FULL_COUNT);
   assign push          = aw_push_valid && aw_push_ready;
   assign empty         = (count == '0);
   assign rd_ptr_inc    = rd_ptr + PTR_W'(1);

   assign head_drop     = q_drop[rd_ptr];
   assign head_id       = q_id[rd_ptr];
   assign head_len      = q_len[rd_ptr];
   assign next_drop     = q_drop[rd_ptr_inc];

   // Entry payload is only meaningful while counted, so it carries no reset.
   always_ff @(posedge axi4_aclk) begin
      if (push) begin
         q_drop[wr_ptr] <= aw_push_drop;
         q_id[wr_ptr]   <= aw_push_id;
         q_len[wr_ptr]  <= aw_push_len;
      end
   end

   // Queue pointers and occupancy; simultaneous push and pop leave count as is.
   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         case ({push, pop})
            2'b10:   count <= count + ONE_COUNT;
            2'b01:   count <= count - ONE_COUNT;
            default: count <= count;
         endcase
      end
   end

   // State register.
   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Beat counter saturates so an overlong burst keeps flagging the error.
   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         beat_cnt <= '0;
      end else if (cnt_clr) begin
         beat_cnt <= '0;
      end else if (cnt_inc && (beat_cnt != BEAT_MAX)) begin
         beat_cnt <= beat_cnt + 8'd1;
      end
   end

   // Capture the ID of a dropped burst as its last beat is sunk.
   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         drop_id <= '0;
      end else if (load_drop_id) begin
         drop_id <= head_id;
      end
   end

   // Length check against the head entry on every accepted beat.
   always_comb begin
      beat_acc     = ((state == ST_FWD)  && s_axi4_wvalid && m_axi4_wready) ||
                     ((state == ST_SINK) && s_axi4_wvalid);
      len_mismatch = s_axi4_wlast ? (beat_cnt != head_len) : (beat_cnt == head_len);
      err_wlast    = beat_acc && len_mismatch;
   end

   // Next-state and handshake routing; the burst boundary always follows WLAST.
   always_comb begin
      state_nxt     = state;
      s_axi4_wready = 1'b0;
      m_axi4_wvalid = 1'b0;
      m_axi4_wlast  = 1'b0;
      drop_valid    = 1'b0;
      pop           = 1'b0;
      cnt_clr       = 1'b0;
      cnt_inc       = 1'b0;
      load_drop_id  = 1'b0;

      case (state)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (!empty) begin
               state_nxt = head_drop ? ST_SINK : ST_FWD;
            end
         end

         ST_FWD: begin
            m_axi4_wvalid = s_axi4_wvalid;
            m_axi4_wlast  = s_axi4_wlast;
            s_axi4_wready = m_axi4_wready;
            if (s_axi4_wvalid && m_axi4_wready) begin
               if (s_axi4_wlast) begin
                  pop     = 1'b1;
                  cnt_clr = 1'b1;
                  // chain straight into the next burst when it is already queued
                  if (count > ONE_COUNT) begin
                     state_nxt = next_drop ? ST_SINK : ST_FWD;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end

         ST_SINK: begin
            s_axi4_wready = 1'b1;
            if (s_axi4_wvalid) begin
               if (s_axi4_wlast) begin
                  pop          = 1'b1;
                  cnt_clr      = 1'b1;
                  load_drop_id = 1'b1;
                  state_nxt    = ST_BREQ;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end

         ST_BREQ: begin
            drop_valid = 1'b1;
            if (drop_ready) begin
               if (empty) begin
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = head_drop ? ST_SINK : ST_FWD;
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
